filtro_fir_mac: RTL
===================

# filtro_fir_mac

Sequential single-multiplier FIR filter on the signed fixed-point filter datapath. Each accepted input sample is shifted into a tap delay line. The block then runs one multiply-accumulate per clock over all taps, with saturation, and emits one filtered sample. Its output word format is identical to the saturating adder stage's operands, so its result feeds that adder directly.

## Interface
- size, 22: total word width (sign + magnitude + fraction), two's complement
- pf, 14: fractional bits (Q7.14 at defaults; 1.0 = 16384)
- taps, 4: number of filter taps, ≥2
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- x_in  input  size  signed input sample
- x_valid  input  1  sample strobe; accepted only when busy=0
- coef  input  taps*size  signed coefficients; c[k] = coef[k*size +: size]; must be stable while busy=1
- y_out  output  size  signed filtered sample, registered
- y_valid  output  1  one-cycle pulse, y_out new this cycle
- busy  output  1  high while a sample is being processed

## Operation
- States: IDLE, MAC, OUT. busy = (state != IDLE).
- IDLE, x_valid=1 at edge:
  - Shift delay line (d[k] ← d[k-1], d[0] ← x_in).
  - acc ← 0, k ← 0, go to MAC.
- IDLE, x_valid=0: hold.
- MAC, one tap per edge:
  - p = d[k] * c[k], full 2*size-bit signed product.
  - q = p >>> pf (arithmetic shift, truncation toward −∞).
  - If q exceeds the size-bit range, saturate q to MAX = 2^(size−1)−1 or MIN = −2^(size−1) by the sign of p.
  - acc ← sat_add(acc, q). sat_add: same-sign operands whose wrapped sum has the opposite sign yield MAX (both ≥0) or MIN (both <0); otherwise the wrapped sum.
  - k increments. After k = taps−1, go to OUT.
- OUT: y_out ← acc, y_valid ← 1 for one cycle, go to IDLE.
- x_valid while busy=1 (including OUT): ignored. Sample lost, no state change.
- coef changes while busy=1: undefined result. Not a supported case.
- Delay line persists across samples. It is cleared only by reset.

## Timing
- Reset (rst=0, asynchronous): y_out=0, y_valid=0, busy=0, state IDLE, acc=0, k=0, all d[k]=0.
- Reset mid-MAC or mid-OUT: abort immediately, no y_valid, delay line cleared.
- Deassertion is synchronous-safe: first accept is possible on the first edge with rst=1.
- x_valid sampled at edge E0:
  - busy=1 from E0.
  - Accumulations occur at edges E0+1 … E0+taps.
  - y_out and y_valid update at E0+taps+1, and busy falls at the same edge.
- Latency: taps+1 cycles. Maximum throughput: one sample per taps+2 cycles (next accept at E0+taps+2 at the earliest).
- y_out holds its value until the next OUT state.

## Test plan
- Impulse, all c=16384 (1.0): x=16384 then three x=0 → y_out = 16384, 16384, 16384, 16384; a fifth sample x=0 → 0. Each y_valid exactly 4+1 edges after its accept.
- Scaling, c0=8192 (0.5), other c=0: x=16384 → y=8192; x=−16384 → y=−8192.
- Positive saturation, all c=2097151: four samples of x=2097151 → final y=2097151 (product and accumulator saturation).
- Negative saturation, all c=2097151: four samples of x=−2097152 → y=−2097152.
- Truncation, c0=1, others 0: x=−1 → y=−1; x=1 → y=0.
- Control:
  - x_valid pulsed during MAC → ignored: exactly one y_valid, delay line unchanged by the pulse.
  - rst=0 at the second MAC edge → no y_valid; all outputs 0 in the same cycle; next impulse behaves as after power-up.

Source files
------------

// File: rtl/filtro_fir_mac.sv
// Sequential single-multiplier FIR filter.
// An accepted sample is shifted into the tap delay line. One saturating
// multiply-accumulate then runs per clock over all taps, and the result is
// presented on y_out with a one-cycle y_valid pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for x_valid; delay line and y_out hold
// ST_MAC  | one tap per clock: acc <- sat_add(acc, sat(d[k]*c[k] >>> pf))
// ST_OUT  | acc copied to y_out, y_valid pulsed, back to ST_IDLE
module filtro_fir_mac #(
  parameter int size = 22,
  parameter int pf   = 14,
  parameter int taps = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [size-1:0]   x_in,
  input  logic                     x_valid,
  input  logic [taps*size-1:0]     coef,
  output logic signed [size-1:0]   y_out,
  output logic                     y_valid,
  output logic                     busy
);

  localparam int KW = (taps > 1) ? $clog2(taps) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(taps - 1);
  localparam logic signed [size-1:0] MAX_V = {1'b0, {(size-1){1'b1}}};
  localparam logic signed [size-1:0] MIN_V = {1'b1, {(size-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic signed [size-1:0] d_q [taps];
  logic signed [size-1:0] d_d [taps];
  logic signed [size-1:0] acc_q, acc_d;
  logic [KW-1:0]          k_q, k_d;
  logic signed [size-1:0] y_out_q, y_out_d;
  logic                   y_valid_q, y_valid_d;

  logic signed [size-1:0]   c_arr [taps];
  logic signed [size-1:0]   d_sel, c_sel;
  logic signed [2*size-1:0] d_ext, c_ext, prod, prod_sh;
  logic signed [size-1:0]   q_sat, sum_wrap, acc_next;
  logic                     q_in_range;

  // Unpack the flat coefficient bus into one word per tap
  always_comb begin
    for (int i = 0; i < taps; i++) begin
      c_arr[i] = coef[i*size +: size];
    end
  end

  // Datapath for the current tap: full product, scale, saturate, accumulate
  always_comb begin
    d_sel   = d_q[k_q];
    c_sel   = c_arr[k_q];
    d_ext   = d_sel;
    c_ext   = c_sel;
    prod    = d_ext * c_ext;
    prod_sh = prod >>> pf;
    // shifted product fits in size bits only if its top size+1 bits agree
    q_in_range = (prod_sh[2*size-1:size-1] == {(size+1){1'b0}}) ||
                 (prod_sh[2*size-1:size-1] == {(size+1){1'b1}});
    if (q_in_range) begin
      q_sat = prod_sh[size-1:0];
    end else if (prod[2*size-1]) begin
      q_sat = MIN_V;
    end else begin
      q_sat = MAX_V;
    end
    sum_wrap = acc_q + q_sat;
    if ((acc_q[size-1] == q_sat[size-1]) && (sum_wrap[size-1] != acc_q[size-1])) begin
      acc_next = acc_q[size-1] ? MIN_V : MAX_V;
    end else begin
      acc_next = sum_wrap;
    end
  end

  // Next-state and output logic of the sequencing FSM
  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    acc_d     = acc_q;
    k_d       = k_q;
    y_out_d   = y_out_q;
    y_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (x_valid) begin
          for (int i = taps - 1; i > 0; i--) begin
            d_d[i] = d_q[i-1];
          end
          d_d[0]  = x_in;
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_next;
        if (k_q == K_LAST) begin
          state_d = ST_OUT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_OUT: begin
        y_out_d   = acc_q;
        y_valid_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any sample in flight and clears the delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < taps; i++) begin
        d_q[i] <= '0;
      end
      acc_q     <= '0;
      k_q       <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
